// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the neuron MAC stage.
//   - state_t        : FSM states of nn_mac_stage.
//   - *_LSB / *_MSB  : bit positions of header and data word fields.
//   - ACC_W_DEFAULT  : default signed accumulator width.
//   - sat_t/sat_add  : saturating signed add, clamped to a run-time width w.
//                      Operands are carried at SAT_W bits; callers
//                      sign-extend into it and keep the low w bits of .val.
//                      Valid for 2 <= w <= SAT_W - 2.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // Header word fields
  localparam int HDR_BIAS_LSB  = 0;
  localparam int HDR_BIAS_MSB  = 15;
  localparam int HDR_SHIFT_LSB = 16;
  localparam int HDR_SHIFT_MSB = 20;

  // Data word fields: two signed int8 activation/weight pairs
  localparam int DATA_ACT0_LSB = 0;
  localparam int DATA_ACT0_MSB = 7;
  localparam int DATA_W0_LSB   = 8;
  localparam int DATA_W0_MSB   = 15;
  localparam int DATA_ACT1_LSB = 16;
  localparam int DATA_ACT1_MSB = 23;
  localparam int DATA_W1_LSB   = 24;
  localparam int DATA_W1_MSB   = 31;

  localparam int ACC_W_DEFAULT = 24;

  // Carrier width for sat_add operands
  localparam int SAT_W = 64;

  typedef struct packed {
    logic                    ovf;
    logic signed [SAT_W-1:0] val;
  } sat_t;

  // a + b clamped to [-2^(w-1), 2^(w-1)-1]; ovf flags a clamp.
  // The sum is formed one bit wider than the carrier (65 = SAT_W + 1) so it
  // cannot wrap before the range check.
  function automatic sat_t sat_add(input logic signed [SAT_W-1:0] a,
                                   input logic signed [SAT_W-1:0] b,
                                   input int unsigned             w);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sat_t                  res;
    sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi  = (65'sd1 <<< (w - 32'd1)) - 65'sd1;
    lo  = -(65'sd1 <<< (w - 32'd1));
    if (sum > hi) begin
      res.ovf = 1'b1;
      res.val = hi[SAT_W-1:0];
    end else if (sum < lo) begin
      res.ovf = 1'b1;
      res.val = lo[SAT_W-1:0];
    end else begin
      res.ovf = 1'b0;
      res.val = sum[SAT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/nn_mac2.sv
// nn_mac2: combinational dual signed 8x8 multiply with a 17-bit signed sum.
// Ports:
//   act0, w0 : first activation/weight pair (signed int8)
//   act1, w1 : second activation/weight pair (signed int8)
//   sum      : act0*w0 + act1*w1 (signed, 17 bits; cannot overflow)
module nn_mac2 (
  input  logic signed [7:0]  act0,
  input  logic signed [7:0]  w0,
  input  logic signed [7:0]  act1,
  input  logic signed [7:0]  w1,
  output logic signed [16:0] sum
);

  logic signed [15:0] prod0_s;
  logic signed [15:0] prod1_s;

  // Each product fits in 16 bits (max magnitude 128*128); the sum needs 17.
  assign prod0_s = 16'(act0) * 16'(w0);
  assign prod1_s = 16'(act1) * 16'(w1);
  assign sum     = 17'(prod0_s) + 17'(prod1_s);

endmodule

// File: rtl/nn_mac_stage.sv
// nn_mac_stage: neuron compute stage fed from the read side of an input FIFO.
// Pops one header word (bias, shift) then N_WORDS data words of two signed
// int8 pairs each, accumulates with saturation, adds the bias, shifts right
// arithmetically, clamps to 8 bits and offers the byte on a valid/ready port.
//
// Build option: define NN_RELU_EN for a ReLU clamp to [0,127]; otherwise the
// result is a signed clamp to [-128,127] (two's complement byte).
//
// Parameters:
//   N_WORDS : data words per neuron (>= 1)
//   ACC_W   : signed accumulator width (17 .. 62)
// Ports:
//   wb_clk_i    : clock
//   wb_rst_ni   : asynchronous active-low reset
//   in_valid_i  : FIFO not empty
//   in_data_i   : FIFO head word
//   in_ready_o  : pop strobe (transfer when in_valid_i && in_ready_o)
//   out_valid_o : result valid
//   out_data_o  : result byte
//   out_ready_i : consumer accepts the result
//   busy_o      : neuron in progress (state != IDLE)
//   ovf_o       : sticky saturation flag of the current neuron
module nn_mac_stage
  import nn_pkg::*;
#(
  parameter int N_WORDS = 4,
  parameter int ACC_W   = ACC_W_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        ovf_o
);

  localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);
  localparam logic signed [ACC_W-1:0] R_MAX  = ACC_W'(8'sh7F);
  localparam logic signed [ACC_W-1:0] R_MIN  = ACC_W'(8'sh80);
  localparam logic signed [ACC_W-1:0] R_ZERO = ACC_W'(8'sh00);

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic                     in_ready_s;
  logic                     take_s;
  logic signed [ACC_W-1:0]  acc_r;
  logic        [CNT_W-1:0]  cnt_r;
  logic signed [15:0]       bias_r;
  logic        [4:0]        shift_r;
  logic                     out_valid_r;
  logic        [7:0]        out_data_r;
  logic                     ovf_r;

  logic signed [16:0]       pair_sum_s;
  sat_t                     acc_sat_s;
  sat_t                     fin_sat_s;
  logic signed [ACC_W-1:0]  fin_val_s;
  logic signed [ACC_W-1:0]  shifted_s;
  logic        [7:0]        res_byte_s;
  logic                     unused_s;

  nn_mac2 u_mac2 (
    .act0 (in_data_i[DATA_ACT0_MSB:DATA_ACT0_LSB]),
    .w0   (in_data_i[DATA_W0_MSB:DATA_W0_LSB]),
    .act1 (in_data_i[DATA_ACT1_MSB:DATA_ACT1_LSB]),
    .w1   (in_data_i[DATA_W1_MSB:DATA_W1_LSB]),
    .sum  (pair_sum_s)
  );

  assign take_s = in_valid_i && in_ready_s;

  // Accumulate step and bias step share the same saturating adder function.
  assign acc_sat_s = sat_add(SAT_W'(acc_r), SAT_W'(pair_sum_s), ACC_W);
  assign fin_sat_s = sat_add(SAT_W'(acc_r), SAT_W'(bias_r), ACC_W);
  assign fin_val_s = fin_sat_s.val[ACC_W-1:0];
  // Arithmetic shift: rounds toward minus infinity.
  assign shifted_s = fin_val_s >>> shift_r;

  // The saturated values always fit in ACC_W bits; the upper carrier bits
  // are pure sign extension.
  assign unused_s = ^{acc_sat_s.val[SAT_W-1:ACC_W], fin_sat_s.val[SAT_W-1:ACC_W]};

  // Final 8-bit clamp of the shifted result
  always_comb begin
    res_byte_s = 8'h00;
`ifdef NN_RELU_EN
    if (shifted_s < R_ZERO) begin
      res_byte_s = 8'h00;
    end else if (shifted_s > R_MAX) begin
      res_byte_s = 8'h7F;
    end else begin
      res_byte_s = shifted_s[7:0];
    end
`else
    if (shifted_s > R_MAX) begin
      res_byte_s = 8'h7F;
    end else if (shifted_s < R_MIN) begin
      res_byte_s = 8'h80;
    end else begin
      res_byte_s = shifted_s[7:0];
    end
`endif
  end

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and pop enable
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid_i) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        in_ready_s = 1'b1;
        if (in_valid_i && (cnt_r == CNT_LAST)) begin
          state_nxt_s = FINISH;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      FINISH: begin
        in_ready_s  = 1'b0;
        state_nxt_s = OUTPUT;
      end
      OUTPUT: begin
        in_ready_s = 1'b0;
        if (out_ready_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUTPUT;
        end
      end
      default: begin
        in_ready_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath: header latch, accumulation, result register and flags
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      bias_r      <= 16'sh0000;
      shift_r     <= 5'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (take_s) begin
            bias_r  <= in_data_i[HDR_BIAS_MSB:HDR_BIAS_LSB];
            shift_r <= in_data_i[HDR_SHIFT_MSB:HDR_SHIFT_LSB];
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
          end
        end
        ACCUM: begin
          if (take_s) begin
            acc_r <= acc_sat_s.val[ACC_W-1:0];
            cnt_r <= cnt_r + CNT_W'(1'b1);
            if (acc_sat_s.ovf) begin
              ovf_r <= 1'b1;
            end
          end
        end
        FINISH: begin
          out_data_r  <= res_byte_s;
          out_valid_r <= 1'b1;
          if (fin_sat_s.ovf) begin
            ovf_r <= 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready_i) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_s;
  assign busy_o      = (state_r != IDLE);
  assign out_valid_o = out_valid_r;
  assign out_data_o  = out_data_r;
  assign ovf_o       = ovf_r;

endmodule

// File: tb/tb_nn_mac_stage.sv
// tb_nn_mac_stage: self-checking bench for nn_mac_stage (N_WORDS=2, ACC_W=16).
// Directed vectors come from a table with hand-computed results; random
// neurons are checked against an integer-arithmetic reference model.
module tb_nn_mac_stage;

  localparam int N_WORDS = 2;
  localparam int ACC_W   = 16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  nn_mac_stage #(.N_WORDS(N_WORDS), .ACC_W(ACC_W)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .ovf_o       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic straight from the neuron rules.
  function automatic void model(input logic [31:0] hdr, input logic [31:0] wa,
                                input logic [31:0] wb, output logic [7:0] y,
                                output logic ovf_exp);
    longint lim, acc, s, r, d, bias;
    logic [31:0] words [2];
    logic [7:0] ab, wbb;
    int sh;
    lim = longint'(1) << (ACC_W - 1);
    words[0] = wa;
    words[1] = wb;
    acc = 0;
    ovf_exp = 1'b0;
    for (int i = 0; i < N_WORDS; i++) begin
      for (int k = 0; k < 2; k++) begin
        ab  = words[i][16*k +: 8];
        wbb = words[i][16*k+8 +: 8];
        acc += longint'(byte'(ab)) * longint'(byte'(wbb));
      end
      if (acc > lim - 1) begin acc = lim - 1; ovf_exp = 1'b1; end
      if (acc < -lim)    begin acc = -lim;    ovf_exp = 1'b1; end
    end
    bias = longint'(shortint'(hdr[15:0]));
    s = acc + bias;
    if (s > lim - 1) begin s = lim - 1; ovf_exp = 1'b1; end
    if (s < -lim)    begin s = -lim;    ovf_exp = 1'b1; end
    sh = int'(hdr[20:16]);
    d  = longint'(1) << sh;
    if (s >= 0) r = s / d;
    else        r = -((-s + d - 1) / d);   // floor division
`ifdef NN_RELU_EN
    if (r < 0)   r = 0;
    if (r > 127) r = 127;
`else
    if (r < -128) r = -128;
    if (r > 127)  r = 127;
`endif
    y = r[7:0];
  endfunction

  // Offer one word after 'gap' idle cycles; returns on the negedge after the transfer.
  task automatic send_word(input logic [31:0] w, input int gap, input string name);
    bit accepted;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = w;
    accepted = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_accepted"}, {31'd0, accepted}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // Called on the negedge after the last data word was popped.
  task automatic collect(input string name, input logic [7:0] exp_data,
                         input logic exp_ovf, input int hold);
    check({name, "_finish_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_finish_busy"}, {31'd0, busy}, 32'd1);
    check({name, "_finish_ready"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check({name, "_latency_valid"}, {31'd0, out_valid}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      check({name, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      check({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({name, "_hold_data"}, {24'd0, out_data}, {24'd0, exp_data});
      @(negedge clk);
    end
    out_ready = 1'b1;
    check({name, "_data"}, {24'd0, out_data}, {24'd0, exp_data});
    check({name, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    check({name, "_ovf_held"}, {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [7:0]  exp_data;
    logic        exp_ovf;
  } vec_t;

  initial begin
    vec_t vecs [9];
    logic [7:0] y;
    logic       yo;
    logic [31:0] h, a, b;

    vecs[0] = '{32'h0000000A, 32'h05FE0403, 32'h00000101, 8'h0D, 1'b0};
    vecs[1] = '{32'h00000000, 32'h7F7F7F7F, 32'h7F7F7F7F, 8'h7F, 1'b1};
    vecs[2] = '{32'h000303E8, 32'h00000000, 32'h00000000, 8'h7D, 1'b0};
    vecs[5] = '{32'h00010007, 32'h00000000, 32'h00000000, 8'h03, 1'b0};
    vecs[8] = '{32'hFFE0000A, 32'h01010101, 32'h01010101, 8'h0E, 1'b0};
`ifdef NN_RELU_EN
    vecs[3] = '{32'h0000FF9C, 32'h00000000, 32'h00000000, 8'h00, 1'b0};
    vecs[4] = '{32'h001F8000, 32'h807F807F, 32'h807F807F, 8'h00, 1'b1};
    vecs[6] = '{32'h0001FFF9, 32'h00000000, 32'h00000000, 8'h00, 1'b0};
    vecs[7] = '{32'h0000FC18, 32'h00000000, 32'h00000000, 8'h00, 1'b0};
`else
    vecs[3] = '{32'h0000FF9C, 32'h00000000, 32'h00000000, 8'h9C, 1'b0};
    vecs[4] = '{32'h001F8000, 32'h807F807F, 32'h807F807F, 8'hFF, 1'b1};
    vecs[6] = '{32'h0001FFF9, 32'h00000000, 32'h00000000, 8'hFC, 1'b0};
    vecs[7] = '{32'h0000FC18, 32'h00000000, 32'h00000000, 8'h80, 1'b0};
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;

    // Reset values, before any clock edge
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Directed table; odd vectors insert FIFO-empty stalls between words
    for (int i = 0; i < 9; i++) begin
      send_word(vecs[i].hdr, i % 2, $sformatf("vec%0d_hdr", i));
      send_word(vecs[i].d0, i % 2, $sformatf("vec%0d_d0", i));
      send_word(vecs[i].d1, i % 2, $sformatf("vec%0d_d1", i));
      collect($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ovf, i % 3);
    end

    // Backpressure: next header waiting with in_valid high for 10 cycles
    send_word(32'h0000000A, 0, "bp_hdr");
    send_word(32'h05FE0403, 0, "bp_d0");
    send_word(32'h00000101, 0, "bp_d1");
    in_valid = 1'b1;
    in_data  = 32'h000303E8;
    collect("bp", 8'h0D, 1'b0, 10);
    check("bp_next_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("bp_next_hdr_taken", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    send_word(32'h00000000, 0, "bp2_d0");
    send_word(32'h00000000, 0, "bp2_d1");
    collect("bp2", 8'h7D, 1'b0, 0);

    // Asynchronous reset after one of two data words
    send_word(32'h00000000, 0, "rs_hdr");
    send_word(32'h7F7F7F7F, 0, "rs_d0");
    check("rs_busy_before", {31'd0, busy}, 32'd1);
    check("rs_data_before", {24'd0, out_data}, 32'h7D);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_busy", {31'd0, busy}, 32'd0);
    check("rs_out_valid", {31'd0, out_valid}, 32'd0);
    check("rs_out_data", {24'd0, out_data}, 32'd0);
    check("rs_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(32'h0000000A, 0, "rs2_hdr");
    send_word(32'h05FE0403, 0, "rs2_d0");
    send_word(32'h00000101, 0, "rs2_d1");
    collect("rs2", 8'h0D, 1'b0, 0);

    // Random neurons against the reference model
    for (int n = 0; n < 40; n++) begin
      h = $urandom;
      a = $urandom;
      b = $urandom;
      if (n % 4 == 0) h[20:16] = 5'd0;   // keep some results unshifted
      model(h, a, b, y, yo);
      send_word(h, int'($urandom_range(0, 2)), $sformatf("rnd%0d_hdr", n));
      send_word(a, int'($urandom_range(0, 2)), $sformatf("rnd%0d_d0", n));
      send_word(b, int'($urandom_range(0, 2)), $sformatf("rnd%0d_d1", n));
      collect($sformatf("rnd%0d", n), y, yo, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
